sysarray_feeder: RTL

SYSARRAY_FEEDER -- requirements
Module: sysarray_feeder

---
 rtl/sysarray_pkg.sv | 9 +
 rtl/sysarray_feeder_mat_store.sv | 33 +++
 rtl/sysarray_feeder.sv | 112 +++++++++++
 3 files changed

// File: rtl/sysarray_pkg.sv
// sysarray_pkg: shared defaults, step-flag constants and FSM states for the feeder
package sysarray_pkg;
    localparam int N_DEF = 31;
    localparam int NDIM_DEF = 3;
    localparam int DRAIN_DEF = 3 * NDIM_DEF;
    localparam int FLG_W = 7;
    localparam logic [FLG_W-1:0] FLG_IDLE = 7'h7F;
    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/sysarray_feeder_mat_store.sv
// mat_store: n x n register bank with one write port and column/row read taps
module mat_store #(
    parameter int W = 32,
    parameter int n = 3,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [IW-1:0] row,
    input  logic [IW-1:0] col,
    input  logic [W-1:0]  data,
    input  logic [IW-1:0] idx,
    output logic [W*n-1:0] col_o,
    output logic [W*n-1:0] row_o
);
    logic [W-1:0] m_q [n][n];
    // clear the whole bank on reset, otherwise store one element per write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < n; i++)
                for (int j = 0; j < n; j++)
                    m_q[i][j] <= '0;
        end else if (we) begin
            m_q[row][col] <= data;
        end
    end
    genvar i;
    for (i = 0; i < n; i++) begin : g_rd
        assign col_o[i*W +: W] = m_q[i][idx];
        assign row_o[i*W +: W] = m_q[idx][i];
    end
endmodule

// File: rtl/sysarray_feeder.sv
// sysarray_feeder: stores matrices A and B and streams them column/row-wise into a systolic array
module sysarray_feeder
    import sysarray_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int n = NDIM_DEF,
    parameter int DRAIN = 3 * n,
    localparam int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [IW-1:0]      wr_row,
    input  logic [IW-1:0]      wr_col,
    input  logic [N:0]         wr_data,
    input  logic               start,
    output logic [FLG_W-1:0]   flg,
    output logic [(N+1)*n-1:0] arr1,
    output logic [(N+1)*n-1:0] arr2,
    output logic               busy,
    output logic               done,
    output logic               wr_err
);
    localparam int W = N + 1;
    localparam int CW = 8 + $clog2(n + DRAIN + 1);
    localparam logic [CW-1:0] SAT = CW'(127);
    localparam logic [CW-1:0] FEED_END = CW'(n - 1);
    localparam logic [CW-1:0] DRAIN_END = CW'(n + DRAIN - 1);
    localparam logic [IW:0] NLIM = (IW + 1)'(n);

    state_t st_q, st_d;
    logic [CW-1:0] s_q, s_d;
    logic [FLG_W-1:0] flg_q, flg_d;
    logic [W*n-1:0] arr1_q, arr1_d, arr2_q, arr2_d;
    logic busy_q, done_q, wr_err_q;
    logic busy_d, done_d, wr_err_d;
    logic wr_ok, feeding;
    logic [W*n-1:0] a_col, a_row, b_col, b_row;
    logic unused_taps;

    assign wr_ok = wr_en && st_q == ST_IDLE && {1'b0, wr_row} < NLIM && {1'b0, wr_col} < NLIM;
    assign unused_taps = ^{a_row, b_col};

    mat_store #(.W(W), .n(n), .IW(IW)) u_a (
        .clk(clk), .rst(rst), .we(wr_ok && !wr_sel), .row(wr_row), .col(wr_col),
        .data(wr_data), .idx(s_q[IW-1:0]), .col_o(a_col), .row_o(a_row)
    );
    mat_store #(.W(W), .n(n), .IW(IW)) u_b (
        .clk(clk), .rst(rst), .we(wr_ok && wr_sel), .row(wr_row), .col(wr_col),
        .data(wr_data), .idx(s_q[IW-1:0]), .col_o(b_col), .row_o(b_row)
    );

    // sequencing: IDLE waits for start, FEED walks n steps, DRAIN flushes, DONE pulses once
    always_comb begin
        st_d = st_q;
        s_d = '0;
        unique case (st_q)
            ST_IDLE: st_d = start ? ST_FEED : ST_IDLE;
            ST_FEED: begin
                s_d = s_q + CW'(1);
                st_d = (s_q == FEED_END) ? ((DRAIN == 0) ? ST_DONE : ST_DRAIN) : ST_FEED;
            end
            ST_DRAIN: begin
                s_d = s_q + CW'(1);
                st_d = (s_q == DRAIN_END) ? ST_DONE : ST_DRAIN;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // output image for the next edge: step flag plus A column / B row while feeding
    always_comb begin
        feeding = st_q == ST_FEED;
        busy_d = feeding || st_q == ST_DRAIN;
        done_d = st_q == ST_DONE;
        wr_err_d = wr_en && !wr_ok;
        flg_d = busy_d ? ((s_q > SAT) ? FLG_IDLE : s_q[FLG_W-1:0]) : FLG_IDLE;
        arr1_d = feeding ? a_col : '0;
        arr2_d = feeding ? b_row : '0;
    end

    // state and registered outputs, reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= ST_IDLE;
            s_q <= '0;
            flg_q <= FLG_IDLE;
            arr1_q <= '0;
            arr2_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            st_q <= st_d;
            s_q <= s_d;
            flg_q <= flg_d;
            arr1_q <= arr1_d;
            arr2_q <= arr2_d;
            busy_q <= busy_d;
            done_q <= done_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign flg = flg_q;
    assign arr1 = arr1_q;
    assign arr2 = arr2_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wr_err = wr_err_q;
endmodule
